// File: rtl/cnn_layer_accel_wht_seq_pkg.sv
// Shared types and helpers for the per-CE weight-table sequence controller.
// Holds the FSM state enum and the mapping from a sequence step to the two DSP lane weight indices.
package cnn_layer_accel_wht_seq_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, FLUSH, EXEC} wht_state_e;

   localparam int         KERNEL_3x3_WEIGHTS = 9;
   localparam logic [3:0] SEQ_PAD_ADDR       = 4'hF;

   // Lane 0 takes the even weight of a step and lane 1 the odd one.
   // Step 4 only has weight 8, so lane 1 points at the zero pad entry.
   function automatic logic [3:0] seq_addr(input logic [2:0] step, input logic lane);
      logic [3:0] addr;
      addr = {step, lane};
      if (lane && (step == 3'd4))
         addr = SEQ_PAD_ADDR;
      return addr;
   endfunction

endpackage

// File: rtl/cnn_layer_accel_wht_seq_gen.sv
// Execute-phase sequencer: step, pass and kernel counters plus lane address generation.
// All outputs are registered so ce_execute, the addresses and the step index change together.
module cnn_layer_accel_wht_seq_gen
   import cnn_layer_accel_wht_seq_pkg::*;
#(
   parameter int C_SEQ_LEN       = 5,
   parameter int C_PIX_CNT_WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       active,
   input  logic                       exec_en,
   input  logic [C_PIX_CNT_WIDTH-1:0] pix_passes,
   input  logic [5:0]                 last_kidx,
   output logic                       ce_execute,
   output logic [2:0]                 ce_cycle_counter,
   output logic [3:0]                 wht_seq_addr0,
   output logic [3:0]                 wht_seq_addr1,
   output logic                       next_kernel,
   output logic                       job_last,
   output logic [5:0]                 kernel_idx
);

   localparam logic [2:0]                 LAST_STEP = 3'(C_SEQ_LEN - 1);
   localparam logic [C_PIX_CNT_WIDTH-1:0] PASS_ONE  = 1;

   logic [2:0]                 step;
   logic [C_PIX_CNT_WIDTH-1:0] pass_cnt;
   logic                       fire;

   assign fire = active && exec_en;

   // pix_passes is already forced to at least 1, so the final pass is pix_passes-1.
   always_ff @(posedge clk) begin
      if (rst) begin
         step             <= '0;
         pass_cnt         <= '0;
         kernel_idx       <= '0;
         ce_execute       <= 1'b0;
         ce_cycle_counter <= '0;
         wht_seq_addr0    <= '0;
         wht_seq_addr1    <= '0;
         next_kernel      <= 1'b0;
         job_last         <= 1'b0;
      end else begin
         ce_execute  <= fire;
         next_kernel <= 1'b0;
         job_last    <= 1'b0;
         if (start) begin
            step       <= '0;
            pass_cnt   <= '0;
            kernel_idx <= '0;
         end else if (fire) begin
            ce_cycle_counter <= step;
            wht_seq_addr0    <= seq_addr(step, 1'b0);
            wht_seq_addr1    <= seq_addr(step, 1'b1);
            if (step == LAST_STEP) begin
               step <= '0;
               if (pass_cnt == (pix_passes - PASS_ONE)) begin
                  pass_cnt    <= '0;
                  next_kernel <= 1'b1;
                  job_last    <= (kernel_idx == last_kidx);
                  kernel_idx  <= kernel_idx + 6'd1;
               end else begin
                  pass_cnt <= pass_cnt + PASS_ONE;
               end
            end else begin
               step <= step + 3'd1;
            end
         end
      end
   end

endmodule

// File: rtl/cnn_layer_accel_wht_seq_ctrl.sv
// Job-level weight-table controller: descriptor intake, weight load path and phase FSM.
// Optional macro CE_WHT_SEQ_CHECK_EN adds a last_kernel consistency check with sticky seq_err.
module cnn_layer_accel_wht_seq_ctrl
   import cnn_layer_accel_wht_seq_pkg::*;
#(
   parameter int C_MAX_KERNELS   = 64,
   parameter int C_SEQ_LEN       = 5,
   parameter int C_PIX_CNT_WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       job_valid,
   output logic                       job_ready,
   input  logic [15:0]                num_kernels_in,
   input  logic [C_PIX_CNT_WIDTH-1:0] pix_per_kernel,
   output logic                       job_accept,
   output logic                       kernel_config_valid,
   output logic [15:0]                num_kernels,
   output logic                       config_mode,
   input  logic                       wht_in_valid,
   output logic                       wht_in_ready,
   input  logic [15:0]                wht_in_data,
   output logic                       wht_config_wren,
   output logic [15:0]                wht_config_data,
   input  logic                       exec_en,
   output logic                       ce_execute,
   output logic [2:0]                 ce_cycle_counter,
   output logic [3:0]                 wht_seq_addr0,
   output logic [3:0]                 wht_seq_addr1,
   output logic                       next_kernel,
   input  logic                       last_kernel,
   output logic                       job_done
`ifdef CE_WHT_SEQ_CHECK_EN
   ,output logic                      seq_err
`endif
);

   localparam logic [C_PIX_CNT_WIDTH-1:0] PIX_ONE = 1;

   wht_state_e                 state;
   logic [3:0]                 w_cnt;
   logic [5:0]                 k_cnt;
   logic [C_PIX_CNT_WIDTH-1:0] pix_passes;
   logic [15:0]                nk_sat;
   logic [C_PIX_CNT_WIDTH-1:0] pix_eff;
   logic                       start;
   logic                       in_hs;
   logic                       gen_active;
   logic                       job_last;
   logic [5:0]                 kernel_idx;

   assign nk_sat     = (num_kernels_in >= 16'(C_MAX_KERNELS)) ? 16'(C_MAX_KERNELS - 1) : num_kernels_in;
   assign pix_eff    = (pix_per_kernel == '0) ? PIX_ONE : pix_per_kernel;
   assign start      = (state == IDLE) && job_valid;
   assign in_hs      = wht_in_valid && wht_in_ready;
   assign gen_active = (state == EXEC) && !job_last;

   // Phase FSM and load path. config_mode stays up through the cycle carrying the
   // final table write, then FLUSH drops it so the table returns to the sequence port.
   always_ff @(posedge clk) begin
      if (rst) begin
         state               <= IDLE;
         job_ready           <= 1'b1;
         job_accept          <= 1'b0;
         kernel_config_valid <= 1'b0;
         num_kernels         <= '0;
         config_mode         <= 1'b0;
         wht_in_ready        <= 1'b0;
         wht_config_wren     <= 1'b0;
         wht_config_data     <= '0;
         job_done            <= 1'b0;
         w_cnt               <= '0;
         k_cnt               <= '0;
         pix_passes          <= PIX_ONE;
      end else begin
         job_accept          <= 1'b0;
         kernel_config_valid <= 1'b0;
         wht_config_wren     <= 1'b0;
         job_done            <= 1'b0;
         case (state)
            IDLE: begin
               if (job_valid) begin
                  job_accept          <= 1'b1;
                  kernel_config_valid <= 1'b1;
                  num_kernels         <= nk_sat;
                  pix_passes          <= pix_eff;
                  w_cnt               <= '0;
                  k_cnt               <= '0;
                  job_ready           <= 1'b0;
                  state               <= LOAD;
               end
            end
            LOAD: begin
               config_mode  <= 1'b1;
               wht_in_ready <= 1'b1;
               if (in_hs) begin
                  wht_config_wren <= 1'b1;
                  wht_config_data <= wht_in_data;
                  if (w_cnt == 4'(KERNEL_3x3_WEIGHTS - 1)) begin
                     w_cnt <= '0;
                     if (k_cnt == num_kernels[5:0]) begin
                        wht_in_ready <= 1'b0;
                        state        <= FLUSH;
                     end else begin
                        k_cnt <= k_cnt + 6'd1;
                     end
                  end else begin
                     w_cnt <= w_cnt + 4'd1;
                  end
               end
            end
            FLUSH: begin
               config_mode <= 1'b0;
               state       <= EXEC;
            end
            EXEC: begin
               if (job_last) begin
                  job_done  <= 1'b1;
                  job_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   cnn_layer_accel_wht_seq_gen #(
      .C_SEQ_LEN       (C_SEQ_LEN),
      .C_PIX_CNT_WIDTH (C_PIX_CNT_WIDTH)
   ) u_seq_gen (
      .clk              (clk),
      .rst              (rst),
      .start            (start),
      .active           (gen_active),
      .exec_en          (exec_en),
      .pix_passes       (pix_passes),
      .last_kidx        (num_kernels[5:0]),
      .ce_execute       (ce_execute),
      .ce_cycle_counter (ce_cycle_counter),
      .wht_seq_addr0    (wht_seq_addr0),
      .wht_seq_addr1    (wht_seq_addr1),
      .next_kernel      (next_kernel),
      .job_last         (job_last),
      .kernel_idx       (kernel_idx)
   );

`ifdef CE_WHT_SEQ_CHECK_EN
   logic [2:0] last_pipe;
   logic [1:0] tail_cnt;
   logic       in_window;

   assign in_window = (state == EXEC) || (tail_cnt != 2'd0);

   // The table's last_kernel lags our kernel index by three cycles; compare through EXEC and its tail.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_pipe <= '0;
         tail_cnt  <= '0;
         seq_err   <= 1'b0;
      end else begin
         last_pipe <= {last_pipe[1:0], (kernel_idx == num_kernels[5:0])};
         if (state == EXEC)
            tail_cnt <= 2'd3;
         else if (tail_cnt != 2'd0)
            tail_cnt <= tail_cnt - 2'd1;
         if (job_accept)
            seq_err <= 1'b0;
         else if (in_window && (last_pipe[2] != last_kernel))
            seq_err <= 1'b1;
      end
   end
`else
   logic [6:0] unused_chk;
   assign unused_chk = {last_kernel, kernel_idx};
`endif

endmodule

// File: doc/cnn_layer_accel_wht_seq_ctrl.md
Name: cnn_layer_accel_wht_seq_ctrl

Overview:
Job-level controller for the per-CE weight table.
- Config phase: accepts a job descriptor, streams 3x3 kernel weights from an upstream valid/ready channel into the table (config_mode, wht_config_wren, wht_config_data).
- Execute phase: drives the two weight-sequence addresses, ce_execute, ce_cycle_counter and next_kernel so the table replays each kernel to the two DSPs.
- Sits between the layer job dispatcher and the weight table, one instance per CE.

Parameters:
C_MAX_KERNELS, 64, table capacity in 3x3 kernels; num_kernels_in must be < C_MAX_KERNELS.
C_SEQ_LEN, 5, execute cycles per kernel pass (9 weights over 2 DSP lanes).
C_PIX_CNT_WIDTH, 16, width of pix_per_kernel.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
job_valid  in  1  job descriptor present
job_ready  out  1  ctrl idle, descriptor taken when job_valid&&job_ready
num_kernels_in  in  16  last kernel index (kernel count minus 1)
pix_per_kernel  in  C_PIX_CNT_WIDTH  sequence passes per kernel, 0 treated as 1
job_accept  out  1  one-cycle pulse on descriptor handshake
kernel_config_valid  out  1  one-cycle pulse with job_accept
num_kernels  out  16  registered num_kernels_in
config_mode  out  1  high throughout config phase
wht_in_valid  in  1  upstream weight valid
wht_in_ready  out  1  ctrl can accept weight
wht_in_data  in  16  weight word
wht_config_wren  out  1  table write strobe
wht_config_data  out  16  table write data
exec_en  in  1  datapath can consume one sequence step this cycle
ce_execute  out  1  table read enable for this step
ce_cycle_counter  out  3  step index 0..C_SEQ_LEN-1
wht_seq_addr0  out  4  lane-0 weight index
wht_seq_addr1  out  4  lane-1 weight index
next_kernel  out  1  pulse: kernel passes complete, advance group
last_kernel  in  1  table's delayed last-kernel flag
job_done  out  1  one-cycle pulse at end of execute

Behaviour:
Reset values:
- job_ready=1; all other outputs 0; FSM=IDLE.
- rst mid-job aborts immediately: no further wren or ce_execute.

States and transitions:
- IDLE: job_ready=1. On job_valid: latch descriptor; pulse job_accept and kernel_config_valid; num_kernels valid from that cycle; go LOAD.
- LOAD:
  - config_mode=1, wht_in_ready=1.
  - Each wht_in_valid&&wht_in_ready registers wht_config_wren=1 and wht_config_data=wht_in_data one cycle later.
  - Weight counter 0..8 per kernel; kernel counter 0..num_kernels.
  - After the write of weight 8 of kernel num_kernels: wht_in_ready=0 the next cycle; go FLUSH.
  - Stalls (wht_in_valid=0) hold counters.
- FLUSH:
  - One cycle, config_mode=0 so the table's address mux returns to the sequence port.
  - Go EXEC.
- EXEC:
  - Each cycle with exec_en=1: ce_execute=1, ce_cycle_counter=step.
  - Lane addresses per step: wht_seq_addr0=2*step; wht_seq_addr1=2*step+1, except step 4 where addr1=4'hF (pad, table returns zero weight).
  - exec_en=0: ce_execute=0, counters hold.
  - step wraps 4->0 and increments the pass counter.
  - When the pass counter reaches pix_per_kernel: pulse next_kernel coincident with that final step-4 ce_execute; clear the pass counter; increment the kernel index.
  - After the next_kernel of kernel index num_kernels: pulse job_done next cycle; go IDLE.
- Outputs are registered; ce_execute, the addresses and ce_cycle_counter change together.

Ordering and overlap rules:
- A new job is not accepted until job_done.
- next_kernel and job_done never overlap.
- The table delays its sequence addresses internally, so this block issues addresses and ce_execute in the same cycle.

Width rules:
- The kernel index is 6 bits.
- num_kernels_in >= C_MAX_KERNELS is saturated to C_MAX_KERNELS-1.

Optional Feature:
Macro CE_WHT_SEQ_CHECK_EN.
- Defined:
  - Shadow-pipe the internal "kernel index == num_kernels" flag by 3 cycles and compare it with last_kernel while in EXEC or the 3 cycles after.
  - On mismatch, set sticky output seq_err (extra 1-bit port), cleared only by rst or job_accept.
- Undefined: last_kernel is unused; no seq_err port.

Decomposition:
Shared package cnn_layer_accel_wht_seq_pkg:
- FSM state enum (IDLE, LOAD, FLUSH, EXEC).
- KERNEL_3x3_WEIGHTS=9.
- SEQ_PAD_ADDR=4'hF.
- Step-to-address mapping function.
Sub-module cnn_layer_accel_wht_seq_gen:
- Step/pass/kernel counters and address generation for EXEC.
- Top keeps the FSM and the load path.

Test Plan:
- Reset then idle, 20 cycles -> all outputs 0 except job_ready=1; no wren or ce_execute.
- Job num_kernels_in=1, pix_per_kernel=2, 18 weights back-to-back -> 18 wren with data in order, config_mode high from job_accept+1 through last wren; EXEC yields 20 ce_execute; addr0 sequence 0,2,4,6,8; addr1 1,3,5,7,F; next_kernel at ce_execute #10 and #20; job_done one cycle after #20.
- Upstream valid toggling 1010… during LOAD -> wren only on handshake cycles; counters hold; final table contents unchanged versus the back-to-back case.
- exec_en deasserted for 3 cycles mid-pass at step 2 -> ce_execute low for those 3 cycles; resumes at step 3 with addr0=6.
- rst asserted in EXEC at kernel 0 step 3 -> next cycle all outputs reset; a new job then loads and executes normally from kernel 0.
- With CE_WHT_SEQ_CHECK_EN and last_kernel forced 0 -> seq_err=1 three cycles after the final kernel's first step; stays set until the next job_accept.
